// File: rtl/keypad_digit_scanner_if.sv
// Keypad-side and digit-side signals of the keypad digit scanner.
// The scanner takes the master modport; the keypad/lock side takes the slave modport.
interface keypad_digit_scanner_if;
    logic [3:0] row;            // active-low rows, asynchronous to the scanner clock
    logic [3:0] col;            // active-low one-hot column drive
    logic [3:0] digit;
    logic       digitValid;
    logic       keyHeld;
    logic       multiKeyError;

    modport master (
        input  row,
        output col, digit, digitValid, keyHeld, multiKeyError
    );

    modport slave (
        output row,
        input  col, digit, digitValid, keyHeld, multiKeyError
    );
endinterface

// File: rtl/keypad_digit_scanner.sv
// 4x4 keypad scanner: column scan, 2-flop row synchronizer, frame debounce, one digit per keypress.
// Optional build macro KEYPAD_REPEAT_EN adds auto-repeat of a held key every REPEAT_FRAMES frames.
module keypad_digit_scanner #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_FRAMES   = 250
) (
    input  logic                   CLK,
    input  logic                   RST,
    keypad_digit_scanner_if.master kp
);

    typedef enum logic [1:0] {S_SCAN, S_DEBOUNCE, S_EMIT, S_WAIT_RELEASE} state_t;
    typedef enum logic [1:0] {F_NONE, F_KEY, F_MULTI} frame_t;

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_FRAMES);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if (SCAN_DIV < 4 || DEBOUNCE_FRAMES < 1 || REPEAT_FRAMES < 1) begin : g_param_check
        $error("keypad_digit_scanner: illegal parameter value");
    end

    logic [3:0]       sync1_q, sync2_q;
    logic [DIV_W-1:0] div_q;
    logic [1:0]       col_idx_q;
    logic [1:0]       acc_cnt_q, acc_cnt_d;   // keys seen this frame, saturating at 2
    logic [3:0]       acc_key_q, acc_key_d;

    state_t           state_q;
    logic [3:0]       cand_q;
    logic [CNT_W-1:0] cnt_q, cnt_inc;
    logic [3:0]       digit_q;
    logic             digit_valid_q;
    logic             key_held_q;
    logic             multi_err_q;

    logic             col_tick, frame_done;
    logic [3:0]       rows_low;
    logic             col_any, col_multi;
    logic [1:0]       row_idx;
    frame_t           frame_kind;

    assign col_tick   = (div_q == DIV_LAST);
    assign frame_done = col_tick && (col_idx_q == 2'd3);
    assign cnt_inc    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
    always_comb begin
        rows_low  = ~sync2_q;
        col_any   = |rows_low;
        col_multi = |(rows_low & (rows_low - 4'd1));
        row_idx   = 2'd0;
        if (rows_low[0])      row_idx = 2'd0;
        else if (rows_low[1]) row_idx = 2'd1;
        else if (rows_low[2]) row_idx = 2'd2;
        else if (rows_low[3]) row_idx = 2'd3;

        acc_cnt_d = acc_cnt_q;
        acc_key_d = acc_key_q;
        if (col_multi) begin
            acc_cnt_d = 2'd2;
        end else if (col_any) begin
            acc_cnt_d = (acc_cnt_q == 2'd0) ? 2'd1 : 2'd2;
            if (acc_cnt_q == 2'd0) acc_key_d = {col_idx_q, row_idx};
        end

        frame_kind = F_NONE;
        if (acc_cnt_d == 2'd1)      frame_kind = F_KEY;
        else if (acc_cnt_d != 2'd0) frame_kind = F_MULTI;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1_q   <= 4'hF;
            sync2_q   <= 4'hF;
            div_q     <= '0;
            col_idx_q <= 2'd0;
            acc_cnt_q <= 2'd0;
            acc_key_q <= 4'd0;
        end else begin
            sync1_q <= kp.row;
            sync2_q <= sync1_q;
            div_q   <= col_tick ? '0 : div_q + DIV_W'(1);
            if (col_tick) begin
                col_idx_q <= col_idx_q + 2'd1;
                acc_cnt_q <= frame_done ? 2'd0 : acc_cnt_d;
                acc_key_q <= frame_done ? 4'd0 : acc_key_d;
            end
        end
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_FRAMES + 1);
    localparam logic [RPT_W-1:0] RPT_MAX = RPT_W'(REPEAT_FRAMES);

    logic [RPT_W-1:0] rpt_q, rpt_inc;
    assign rpt_inc = (rpt_q == RPT_MAX) ? rpt_q : rpt_q + RPT_W'(1);
`endif

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= S_SCAN;
            cand_q        <= 4'd0;
            cnt_q         <= '0;
            digit_q       <= 4'd0;
            digit_valid_q <= 1'b0;
            key_held_q    <= 1'b0;
            multi_err_q   <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rpt_q         <= '0;
`endif
        end else begin
            digit_valid_q <= 1'b0;
            multi_err_q   <= 1'b0;
            case (state_q)
                S_SCAN: begin
                    if (frame_done) begin
                        case (frame_kind)
                            F_KEY: begin
                                cand_q  <= acc_key_d;
                                cnt_q   <= CNT_ONE;
                                state_q <= (DEBOUNCE_FRAMES == 1) ? S_EMIT : S_DEBOUNCE;
                            end
                            F_MULTI: begin
                                multi_err_q <= 1'b1;
                                cnt_q       <= '0;
                            end
                            default: ;
                        endcase
                    end
                end
                S_DEBOUNCE: begin
                    if (frame_done) begin
                        case (frame_kind)
                            F_KEY: begin
                                if (acc_key_d == cand_q) begin
                                    cnt_q <= cnt_inc;
                                    if (cnt_inc == CNT_MAX) state_q <= S_EMIT;
                                end else begin
                                    cand_q <= acc_key_d;
                                    cnt_q  <= CNT_ONE;
                                end
                            end
                            F_MULTI: begin
                                multi_err_q <= 1'b1;
                                cnt_q       <= '0;
                                state_q     <= S_SCAN;
                            end
                            default: begin
                                cnt_q   <= '0;
                                state_q <= S_SCAN;
                            end
                        endcase
                    end
                end
                S_EMIT: begin
                    digit_q       <= cand_q;
                    digit_valid_q <= 1'b1;
                    key_held_q    <= 1'b1;
                    cnt_q         <= '0;
                    state_q       <= S_WAIT_RELEASE;
`ifdef KEYPAD_REPEAT_EN
                    rpt_q         <= '0;
`endif
                end
                S_WAIT_RELEASE: begin
                    if (frame_done) begin
                        case (frame_kind)
                            F_NONE: begin
                                if (cnt_inc == CNT_MAX) begin
                                    cnt_q      <= '0;
                                    key_held_q <= 1'b0;
                                    state_q    <= S_SCAN;
                                end else begin
                                    cnt_q <= cnt_inc;
                                end
`ifdef KEYPAD_REPEAT_EN
                                rpt_q <= '0;
`endif
                            end
                            F_MULTI: begin
                                multi_err_q <= 1'b1;
                                cnt_q       <= '0;
`ifdef KEYPAD_REPEAT_EN
                                rpt_q       <= '0;
`endif
                            end
                            default: begin
                                // A different key while held only restarts the release count.
                                cnt_q <= '0;
`ifdef KEYPAD_REPEAT_EN
                                if (acc_key_d == cand_q) begin
                                    if (rpt_inc == RPT_MAX) begin
                                        digit_q       <= cand_q;
                                        digit_valid_q <= 1'b1;
                                        rpt_q         <= '0;
                                    end else begin
                                        rpt_q <= rpt_inc;
                                    end
                                end else begin
                                    rpt_q <= '0;
                                end
`endif
                            end
                        endcase
                    end
                end
                default: state_q <= S_SCAN;
            endcase
        end
    end

    assign kp.col           = ~(4'b0001 << col_idx_q);
    assign kp.digit         = digit_q;
    assign kp.digitValid    = digit_valid_q;
    assign kp.keyHeld       = key_held_q;
    assign kp.multiKeyError = multi_err_q;

endmodule
